conv_window_3x3: RTL and testbench
==================================

# conv_window_3x3

Streaming 3x3 window generator that sits directly upstream of the 3x3 convolution stage. It accepts a raster-order pixel stream, one pixel per valid beat, and buffers the two previous image rows. For every pixel that completes a full 3x3 neighbourhood, it presents nine registered window pixels, ordered to map one-to-one onto the convolution's in0..in8 inputs. Weights are not handled here.

## Interface
- IMG_W, 28: image width in pixels (≥3)
- IMG_H, 28: image height in rows (≥3)
- PIX_W, 16: pixel width in bits
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  pixel beat qualifier
- in_sof  input  1  start of frame; meaningful only with in_valid
- in_pix  input  PIX_W  pixel, raster order (row-major, left to right)
- win0..win8  output  PIX_W each  window pixels; win0 = top-left, win2 = top-right, win6 = bottom-left, win8 = bottom-right (current pixel)
- win_valid  output  1  one-cycle strobe: win0..win8 form a new valid window
- frame_done  output  1  one-cycle strobe coincident with the last window of a frame

## Operation
- Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) advance only on in_valid beats. col wraps to 0 and increments row. At (IMG_H-1, IMG_W-1), both counters wrap to (0,0).
- in_valid && in_sof: the beat is taken as pixel (0,0), whatever the counter state. The partial frame is abandoned, and no window from it is emitted after this beat. in_sof without in_valid is ignored.
- Two line buffers, each IMG_W deep, are written and read only on valid beats. lb0 delays the stream by IMG_W beats, and lb1 delays lb0's output by IMG_W beats.
- On each valid beat, the 3x3 register array shifts left by one column. The new right column is taken as: top = lb1 out, mid = lb0 out, bottom = in_pix.
- A window is valid when the accepted beat has row ≥ 2 and col ≥ 2. Windows that would straddle a row boundary are never flagged.
- Each frame yields (IMG_W-2)·(IMG_H-2) windows with no padding. The window emitted for pixel (r,c) is centred at (r-1,c-1).
- Pixels pass through unmodified. The block does no arithmetic on pixel data.
- Idle cycles (in_valid=0) freeze all state. win0..win8 hold their last values, and win_valid is 0.

## Timing
- Latency: win_valid and the window are registered. They appear 1 cycle after the clk edge that samples the completing in_valid beat.
- Throughput: one window per cycle, sustained under continuous in_valid.
- frame_done goes high in the same cycle as win_valid for pixel (IMG_H-1, IMG_W-1).
- Reset values: win0..win8 = 0, win_valid = 0, frame_done = 0, col = row = 0, plus WIN_ROW/WIN_COL when compiled in.
- Line buffer contents are not reset. Stale data is never flagged because row < 2 after reset.
- Reset asserted mid-frame: outputs clear asynchronously. The next valid beat after deassertion is pixel (0,0).
- A frame start (in_valid && in_sof) on the same beat as the natural wrap at frame end behaves the same as the wrap alone.

## Configuration
- CONV_WINDOW_COORD_EN defined: adds outputs win_row and win_col, each $clog2(IMG_H)/$clog2(IMG_W) bits wide. They are registered with the window, hold the window centre coordinate (r-1, c-1), and reset to 0.
- CONV_WINDOW_COORD_EN undefined: these ports and their registers do not exist. All other behaviour is identical.

## Structure
- Shared package cnn_pkg holds PIX_W_DEF = 16 and the pixel typedef pix_t. The convolution stage and other CNN blocks use the same definitions.
- Sub-module conv_line_buffer: an IMG_W-deep, PIX_W-wide delay line with a write-enable (shift on enable). It is instantiated twice and may be mapped to RAM.
- The top level holds the counters, the 3x3 register array, and the valid/frame_done logic.

## Test plan
- IMG_W=IMG_H=4, pixels r*4+c streamed continuously with sof on pixel 0 → the first win_valid comes 1 cycle after pixel 10, with win0..win8 = 0,1,2,4,5,6,8,9,10. Exactly 4 windows are emitted. The last window is 5,6,7,9,10,11,13,14,15, with frame_done high.
- Same stream with random 0–3 idle cycles between beats → the same 4 windows, in the same order and with the same values. win_valid is never high during idle cycles.
- Two back-to-back frames (second frame = pixel+100) → 8 windows. The first window of frame 2 is 100,101,102,104,105,106,108,109,110. No window mixes data from the two frames' rows.
- in_sof re-asserted at frame-1 pixel 9 → no further frame-1 windows. The new frame's first window follows its 11th beat.
- rst pulsed after pixel 10 → all outputs go to 0 immediately. A fresh frame then produces the exact 4-window result.
- With CONV_WINDOW_COORD_EN defined → win_row/win_col = (1,1), (1,2), (2,1), (2,2) for the four windows.

Source files
------------

// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg -- definitions shared by the CNN pipeline blocks (window generator,
// convolution stage, ...).
//   PIX_W_DEF : default pixel width in bits
//   pix_t     : pixel type at the default width
//   cnt_w()   : width of a counter that spans 0..n-1 (never less than 1 bit)
// ---------------------------------------------------------------------------
package cnn_pkg;

  localparam int PIX_W_DEF = 16;

  typedef logic [PIX_W_DEF-1:0] pix_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// ---------------------------------------------------------------------------
// conv_line_buffer -- DEPTH-deep, PIX_W-wide delay line.
// The line shifts only when en_i is high. dout_o is the pixel that was written
// DEPTH enabled beats ago. The contents are not reset, so the line can map
// onto RAM or SRL primitives.
//   clk    : clock, rising edge
//   en_i   : shift enable (one accepted pixel)
//   din_i  : pixel written on this beat
//   dout_o : pixel written DEPTH beats earlier (combinational from storage)
// ---------------------------------------------------------------------------
module conv_line_buffer #(
  parameter int DEPTH = 28,
  parameter int PIX_W = 16
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] dout_o
);

  // Index 0 holds the newest pixel and DEPTH-1 the oldest.
  logic [DEPTH-1:0][PIX_W-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (en_i) sr_q <= {sr_q[DEPTH-2:0], din_i};
  end

  // The oldest entry is read on the same beat it is overwritten, which gives
  // a delay of exactly DEPTH beats.
  assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/conv_window_3x3.sv
// ---------------------------------------------------------------------------
// conv_window_3x3 -- streaming 3x3 window generator for the conv stage.
// It takes a raster-order pixel stream and keeps the two previous rows in line
// buffers. For every pixel that completes a full 3x3 neighbourhood, it emits a
// registered window: win0 = top-left ... win8 = bottom-right (the current
// pixel). There is no padding, and no window is flagged across a row boundary.
//
//   clk, rst        : clock (rising edge); reset is async, active high
//   in_valid        : pixel beat qualifier; all state is frozen when low
//   in_sof          : start of frame, forces this beat to pixel (0,0)
//   in_pix          : pixel data
//   win0..win8      : window pixels, held between windows
//   win_valid       : one-cycle strobe for a new window
//   frame_done      : strobe that coincides with the last window of a frame
//   win_row/win_col : window centre coordinate (r-1, c-1). These two ports
//                     exist only when the macro CONV_WINDOW_COORD_EN is defined.
// ---------------------------------------------------------------------------
module conv_window_3x3
  import cnn_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [PIX_W-1:0]         in_pix,
  output logic [PIX_W-1:0]         win0,
  output logic [PIX_W-1:0]         win1,
  output logic [PIX_W-1:0]         win2,
  output logic [PIX_W-1:0]         win3,
  output logic [PIX_W-1:0]         win4,
  output logic [PIX_W-1:0]         win5,
  output logic [PIX_W-1:0]         win6,
  output logic [PIX_W-1:0]         win7,
  output logic [PIX_W-1:0]         win8,
  output logic                     win_valid,
`ifdef CONV_WINDOW_COORD_EN
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
`endif
  output logic                     frame_done
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  // ---------------------------------------------------------------------
  // Line buffers: lb[0] delays the input by one row, lb[1] by two rows.
  // ---------------------------------------------------------------------
  logic [1:0][PIX_W-1:0] lb_din;
  logic [1:0][PIX_W-1:0] lb_dout;

  assign lb_din[0] = in_pix;
  assign lb_din[1] = lb_dout[0];

  for (genvar g = 0; g < 2; g++) begin : g_lb
    conv_line_buffer #(
      .DEPTH (IMG_W),
      .PIX_W (PIX_W)
    ) u_lb (
      .clk    (clk),
      .en_i   (in_valid),
      .din_i  (lb_din[g]),
      .dout_o (lb_dout[g])
    );
  end

  // New right-hand column of the window: [0] top, [1] middle, [2] bottom.
  logic [2:0][PIX_W-1:0] col_in;
  assign col_in = {in_pix, lb_dout[0], lb_dout[1]};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [COL_W-1:0]            col_q, col_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic [2:0][2:0][PIX_W-1:0]  win_q, win_d;   // [row][col]
  logic                        win_valid_q, win_valid_d;
  logic                        frame_done_q, frame_done_d;

  // Position of the beat being accepted. A start of frame overrides the
  // counters, so a partial frame is dropped at once.
  logic [COL_W-1:0] eff_col;
  logic [ROW_W-1:0] eff_row;
  logic             col_last;
  logic             row_last;
  logic             win_hit;

  always_comb begin
    eff_col  = in_sof ? '0 : col_q;
    eff_row  = in_sof ? '0 : row_q;
    col_last = (eff_col == COL_LAST);
    row_last = (eff_row == ROW_LAST);
    win_hit  = (eff_row >= ROW_W'(2)) && (eff_col >= COL_W'(2));
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (in_valid) begin
      col_d = col_last ? '0 : eff_col + COL_W'(1);
      if (col_last) row_d = row_last ? '0 : eff_row + ROW_W'(1);
      else          row_d = eff_row;
      for (int r = 0; r < 3; r++) begin
        win_d[r] = {col_in[r], win_q[r][2], win_q[r][1]};
      end
      win_valid_d  = win_hit;
      frame_done_d = row_last && col_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef CONV_WINDOW_COORD_EN
  // The centre coordinate updates only with a flagged window. Between
  // windows it holds, like the window pixels.
  logic [ROW_W-1:0] win_row_q, win_row_d;
  logic [COL_W-1:0] win_col_q, win_col_d;

  always_comb begin
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    if (in_valid && win_hit) begin
      win_row_d = eff_row - ROW_W'(1);
      win_col_d = eff_col - COL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else begin
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
    end
  end

  assign win_row = win_row_q;
  assign win_col = win_col_q;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign win0       = win_q[0][0];
  assign win1       = win_q[0][1];
  assign win2       = win_q[0][2];
  assign win3       = win_q[1][0];
  assign win4       = win_q[1][1];
  assign win5       = win_q[1][2];
  assign win6       = win_q[2][0];
  assign win7       = win_q[2][1];
  assign win8       = win_q[2][2];
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_3x3.sv
module tb_conv_window_3x3;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic [PW-1:0] in_pix = '0;
  logic [PW-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic win_valid, frame_done;
`ifdef CONV_WINDOW_COORD_EN
  logic [$clog2(H)-1:0] win_row;
  logic [$clog2(W)-1:0] win_col;
`endif

  conv_window_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_pix     (in_pix),
    .win0       (win0),
    .win1       (win1),
    .win2       (win2),
    .win3       (win3),
    .win4       (win4),
    .win5       (win5),
    .win6       (win6),
    .win7       (win7),
    .win8       (win8),
    .win_valid  (win_valid),
`ifdef CONV_WINDOW_COORD_EN
    .win_row    (win_row),
    .win_col    (win_col),
`endif
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef logic [8:0][PW-1:0] win_t;
  typedef struct {
    win_t w;
    logic done;
    int   r;
    int   c;
  } sb_t;

  sb_t  sbq[$];
  win_t got[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   win_cnt = 0;

  // Reference model: the current frame image and the raster position.
  logic [PW-1:0] img [H][W];
  int mr = 0;
  int mc = 0;

  win_t wv;
  assign wv = {win8, win7, win6, win5, win4, win3, win2, win1, win0};

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // A pixel beat. The expected window, if any, is pushed when the beat is driven.
  task automatic beat(input logic [PW-1:0] v, input logic sof);
    sb_t e;
    if (sof) begin mr = 0; mc = 0; end
    img[mr][mc] = v;
    if (mr >= 2 && mc >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.w[i*3+j] = img[mr-2+i][mc-2+j];
      e.done = (mr == H-1) && (mc == W-1);
      e.r = mr - 1;
      e.c = mc - 1;
      sbq.push_back(e);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
      if (mr == H) mr = 0;
    end
    in_valid = 1'b1;
    in_sof   = sof;
    in_pix   = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input int base, input int max_gap);
    for (int p = 0; p < W*H; p++) begin
      beat(PW'(base + p), p == 0);
      if (max_gap > 0) idle($urandom_range(max_gap, 0));
    end
  endtask

  task automatic clr_stats();
    win_cnt = 0;
    got.delete();
  endtask

  // Monitor: the state seen at a falling edge reflects the preceding rising edge.
  logic last_vld;
  always @(posedge clk or posedge rst) begin
    if (rst) last_vld <= 1'b0;
    else     last_vld <= in_valid;
  end

  sb_t me;
  always @(negedge clk) begin
    if (!rst) begin
      if (!last_vld) chk("idle_win_valid", {159'd0, win_valid}, 160'd0);
      if (!win_valid) chk("frame_done_no_win", {159'd0, frame_done}, 160'd0);
      if (win_valid && last_vld) begin
        if (sbq.size() == 0) begin
          chk("unexpected_window", 160'(wv), 160'd0 - 160'd1);
        end else begin
          me = sbq.pop_front();
          chk("window", 160'(wv), 160'(me.w));
          chk("frame_done", {159'd0, frame_done}, {159'd0, me.done});
`ifdef CONV_WINDOW_COORD_EN
          chk("win_row", 160'(win_row), 160'(me.r));
          chk("win_col", 160'(win_col), 160'(me.c));
`endif
          got.push_back(wv);
          win_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  win_t e_a, e_b;

  initial begin
    // Reset state
    rst = 1'b1;
    #12;
    chk("rst_win", 160'(wv), 160'd0);
    chk("rst_win_valid", {159'd0, win_valid}, 160'd0);
    chk("rst_frame_done", {159'd0, frame_done}, 160'd0);
`ifdef CONV_WINDOW_COORD_EN
    chk("rst_win_row", 160'(win_row), 160'd0);
    chk("rst_win_col", 160'(win_col), 160'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // 1: a continuous frame
    clr_stats();
    frame(0, 0);
    idle(3);
    chk("t1_count", 160'(win_cnt), 160'd4);
    chk("t1_sb_empty", 160'(sbq.size()), 160'd0);
    e_a = {16'd10, 16'd9, 16'd8, 16'd6, 16'd5, 16'd4, 16'd2, 16'd1, 16'd0};
    e_b = {16'd15, 16'd14, 16'd13, 16'd11, 16'd10, 16'd9, 16'd7, 16'd6, 16'd5};
    if (got.size() == 4) begin
      chk("t1_first", 160'(got[0]), 160'(e_a));
      chk("t1_last", 160'(got[3]), 160'(e_b));
    end else chk("t1_got_size", 160'(got.size()), 160'd4);

    // 2: the same frame with random idle gaps
    clr_stats();
    frame(0, 3);
    idle(3);
    chk("t2_count", 160'(win_cnt), 160'd4);
    chk("t2_sb_empty", 160'(sbq.size()), 160'd0);
    if (got.size() == 4) chk("t2_first", 160'(got[0]), 160'(e_a));

    // 3: back-to-back frames, the second offset by 100
    clr_stats();
    frame(0, 0);
    frame(100, 0);
    idle(3);
    chk("t3_count", 160'(win_cnt), 160'd8);
    chk("t3_sb_empty", 160'(sbq.size()), 160'd0);
    e_b = {16'd110, 16'd109, 16'd108, 16'd106, 16'd105, 16'd104, 16'd102, 16'd101, 16'd100};
    if (got.size() == 8) chk("t3_f2_first", 160'(got[4]), 160'(e_b));
    else chk("t3_got_size", 160'(got.size()), 160'd8);

    // 4: start of frame re-asserted at frame-1 pixel 9
    clr_stats();
    for (int p = 0; p < 9; p++) beat(PW'(p), p == 0);
    frame(200, 0);
    idle(3);
    chk("t4_count", 160'(win_cnt), 160'd4);
    chk("t4_sb_empty", 160'(sbq.size()), 160'd0);
    e_b = {16'd210, 16'd209, 16'd208, 16'd206, 16'd205, 16'd204, 16'd202, 16'd201, 16'd200};
    if (got.size() == 4) chk("t4_first", 160'(got[0]), 160'(e_b));

    // 5: reset pulsed after pixel 10, then a fresh frame without sof
    clr_stats();
    for (int p = 0; p < 11; p++) beat(PW'(p), p == 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_win", 160'(wv), 160'd0);
    chk("t5_rst_win_valid", {159'd0, win_valid}, 160'd0);
    chk("t5_rst_frame_done", {159'd0, frame_done}, 160'd0);
    chk("t5_pre_rst_count", 160'(win_cnt), 160'd1);
    sbq.delete();
    mr = 0;
    mc = 0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    idle(1);
    clr_stats();
    for (int p = 0; p < W*H; p++) beat(PW'(p), 1'b0);
    idle(3);
    chk("t5_count", 160'(win_cnt), 160'd4);
    chk("t5_sb_empty", 160'(sbq.size()), 160'd0);
    e_b = {16'd15, 16'd14, 16'd13, 16'd11, 16'd10, 16'd9, 16'd7, 16'd6, 16'd5};
    if (got.size() == 4) begin
      chk("t5_first", 160'(got[0]), 160'(e_a));
      chk("t5_last", 160'(got[3]), 160'(e_b));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
